// File: rtl/data_mem_responder.sv
// Load/store responder with a word-organised RAM, programmable wait states,
// RV32 store lane merging, load extension and alignment/range error flagging.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [2:0]  req_load_type_i,
    input  logic [1:0]  req_store_type_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    localparam int unsigned AddrW   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  CntInit = 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        hold_write_q;
    logic [2:0]  hold_ltype_q;
    logic [1:0]  hold_stype_q;
    logic [31:0] hold_addr_q;
    logic [31:0] hold_wdata_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic        accept, do_access, mem_we;
    logic        cur_write;
    logic [2:0]  cur_ltype;
    logic [1:0]  cur_stype;
    logic [31:0] cur_addr, cur_wdata;
    logic        type_err, align_err, range_err, acc_err;
    logic [31:0] rd_word, rd_shift, load_val, acc_rdata;
    logic [31:0] st_data, new_word;
    logic [3:0]  st_mask;

    assign accept = (state_q == StIdle) && req_valid_i;

    // With zero wait states the access happens on the accept edge, straight from the inputs.
    assign do_access = (accept && (WAIT_STATES == 0)) || ((state_q == StWait) && (cnt_q == '0));

    assign cur_write = (state_q == StIdle) ? req_write_i      : hold_write_q;
    assign cur_ltype = (state_q == StIdle) ? req_load_type_i  : hold_ltype_q;
    assign cur_stype = (state_q == StIdle) ? req_store_type_i : hold_stype_q;
    assign cur_addr  = (state_q == StIdle) ? req_addr_i       : hold_addr_q;
    assign cur_wdata = (state_q == StIdle) ? req_wdata_i      : hold_wdata_q;

    always_comb begin
        type_err  = 1'b0;
        align_err = 1'b0;
        if (cur_write) begin
            unique case (cur_stype)
                2'b00:   align_err = 1'b0;
                2'b01:   align_err = cur_addr[0];
                2'b10:   align_err = (cur_addr[1:0] != 2'b00);
                default: type_err  = 1'b1;
            endcase
        end else begin
            unique case (cur_ltype)
                3'b000, 3'b100: align_err = 1'b0;
                3'b001, 3'b101: align_err = cur_addr[0];
                3'b010:         align_err = (cur_addr[1:0] != 2'b00);
                default:        type_err  = 1'b1;
            endcase
        end
    end

    assign range_err = ({2'b00, cur_addr[31:2]} >= DEPTH_WORDS);
    assign acc_err   = type_err || align_err || range_err;

    // Out-of-range indices only reach here on the error path, where the data is discarded.
    assign rd_word  = mem[cur_addr[AddrW+1:2]];
    assign rd_shift = rd_word >> {cur_addr[1:0], 3'b000};

    always_comb begin
        unique case (cur_ltype[1:0])
            2'b00:   load_val = cur_ltype[2] ? {24'h0, rd_shift[7:0]}
                                             : {{24{rd_shift[7]}}, rd_shift[7:0]};
            2'b01:   load_val = cur_ltype[2] ? {16'h0, rd_shift[15:0]}
                                             : {{16{rd_shift[15]}}, rd_shift[15:0]};
            default: load_val = rd_word;
        endcase
    end

    assign acc_rdata = (acc_err || cur_write) ? 32'h0 : load_val;

    always_comb begin
        unique case (cur_stype)
            2'b00: begin
                st_data = {4{cur_wdata[7:0]}};
                st_mask = 4'b0001 << cur_addr[1:0];
            end
            2'b01: begin
                st_data = {2{cur_wdata[15:0]}};
                st_mask = cur_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_data = cur_wdata;
                st_mask = 4'b1111;
            end
        endcase
        for (int i = 0; i < 4; i++) begin
            new_word[i*8 +: 8] = st_mask[i] ? st_data[i*8 +: 8] : rd_word[i*8 +: 8];
        end
    end

    // Held off during reset so a request presented while in reset never lands in the RAM.
    assign mem_we = do_access && cur_write && !acc_err && rst_n;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[cur_addr[AddrW+1:2]] <= new_word;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (WAIT_STATES == 0) begin
                        state_d = StResp;
                        rdata_d = acc_rdata;
                        err_d   = acc_err;
                    end else begin
                        state_d = StWait;
                        cnt_d   = CntInit;
                    end
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    state_d = StResp;
                    rdata_d = acc_rdata;
                    err_d   = acc_err;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
                rdata_d = 32'h0;
                err_d   = 1'b0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            hold_write_q <= 1'b0;
            hold_ltype_q <= '0;
            hold_stype_q <= '0;
            hold_addr_q  <= '0;
            hold_wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                hold_write_q <= req_write_i;
                hold_ltype_q <= req_load_type_i;
                hold_stype_q <= req_store_type_i;
                hold_addr_q  <= req_addr_i;
                hold_wdata_q <= req_wdata_i;
            end
        end
    end

    assign req_ready_o = (state_q == StIdle);
    assign rsp_valid_o = (state_q == StResp);
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (1, 0 and 3 wait states), directed
// vector table, reset corner cases, back-to-back throughput and randomized model checks.
module tb_data_mem_responder;

    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid [NI];
    logic        req_ready [NI];
    logic        req_write [NI];
    logic [2:0]  req_ltype [NI];
    logic [1:0]  req_stype [NI];
    logic [31:0] req_addr  [NI];
    logic [31:0] req_wdata [NI];
    logic        rsp_valid [NI];
    logic [31:0] rsp_rdata [NI];
    logic        rsp_err   [NI];

    int total = 0;
    int bad   = 0;

    logic [7:0] mm [NI][256];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        data_mem_responder #(
            .DEPTH_WORDS(1024),
            .WAIT_STATES((g == 0) ? 1 : ((g == 1) ? 0 : 3))
        ) u_dut (
            .clk             (clk),
            .rst_n           (rst_n),
            .req_valid_i     (req_valid[g]),
            .req_ready_o     (req_ready[g]),
            .req_write_i     (req_write[g]),
            .req_load_type_i (req_ltype[g]),
            .req_store_type_i(req_stype[g]),
            .req_addr_i      (req_addr[g]),
            .req_wdata_i     (req_wdata[g]),
            .rsp_valid_o     (rsp_valid[g]),
            .rsp_rdata_o     (rsp_rdata[g]),
            .rsp_err_o       (rsp_err[g])
        );
    end

    function automatic int ws(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Byte-addressed reference memory: stores scatter bytes, loads gather and extend.
    task automatic model_access(input int k, input bit wr, input bit [2:0] lt, input bit [1:0] st,
                                input bit [31:0] a, input bit [31:0] wd,
                                output bit [31:0] rd, output bit er);
        int size;
        bit legal, sgn;
        longint unsigned val;
        sgn = 1'b0;
        if (wr) begin
            legal = (st != 2'd3);
            size  = (st == 2'd0) ? 1 : ((st == 2'd1) ? 2 : 4);
        end else begin
            legal = (lt == 3'd0) || (lt == 3'd1) || (lt == 3'd2) || (lt == 3'd4) || (lt == 3'd5);
            size  = (lt[1:0] == 2'd0) ? 1 : ((lt[1:0] == 2'd1) ? 2 : 4);
            sgn   = (lt[2] == 1'b0);
        end
        er = !legal || ((a % size) != 0) || ((a / 4) >= 1024);
        rd = 32'h0;
        if (!er && (a + 4 <= 256)) begin
            if (wr) begin
                for (int i = 0; i < size; i++) mm[k][a + i] = wd[8*i +: 8];
            end else begin
                val = 0;
                for (int i = 0; i < size; i++) val = val + (longint'(mm[k][a + i]) << (8 * i));
                if (sgn && size < 4 && val >= (64'd1 << (8 * size - 1)))
                    val = val + 64'hFFFF_FFFF - (64'd1 << (8 * size)) + 1;
                rd = val[31:0];
            end
        end
    endtask

    task automatic do_txn(input int k, input bit wr, input bit [2:0] lt, input bit [1:0] st,
                          input bit [31:0] a, input bit [31:0] wd,
                          output logic [31:0] rd, output logic er);
        int n;
        bit got;
        @(negedge clk);
        check("ready_idle", 32'(req_ready[k]), 32'd1);
        req_valid[k] = 1'b1;
        req_write[k] = wr;
        req_ltype[k] = lt;
        req_stype[k] = st;
        req_addr[k]  = a;
        req_wdata[k] = wd;
        @(posedge clk);
        #1;
        // Scramble the inputs: the captured request must be the one used.
        req_valid[k] = 1'b0;
        req_write[k] = 1'($urandom);
        req_ltype[k] = 3'($urandom);
        req_stype[k] = 2'($urandom);
        req_addr[k]  = $urandom;
        req_wdata[k] = $urandom;
        n = 0;
        got = 1'b0;
        while (!got && n < 30) begin
            @(negedge clk);
            n++;
            if (rsp_valid[k]) got = 1'b1;
            else check("ready_busy", 32'(req_ready[k]), 32'd0);
        end
        check("rsp_seen", 32'(got), 32'd1);
        check("latency", 32'(n), 32'(ws(k) + 1));
        rd = rsp_rdata[k];
        er = rsp_err[k];
        check("ready_in_rsp", 32'(req_ready[k]), 32'd0);
        @(negedge clk);
        check("rsp_pulse", 32'(rsp_valid[k]), 32'd0);
        check("ready_after", 32'(req_ready[k]), 32'd1);
    endtask

    task automatic set_b2b(input int k, input int j);
        req_write[k] = 1'b0;
        req_ltype[k] = (j % 2 == 1) ? 3'b100 : 3'b010;
        req_addr[k]  = (j % 2 == 1) ? 32'(4 * j + 3) : 32'(4 * j);
        req_wdata[k] = $urandom;
    endtask

    task automatic b2b(input int k);
        bit [31:0] q_rd[$];
        bit        q_er[$];
        bit [31:0] e_rd;
        bit        e_er;
        int acc, nrsp, last, cyc;
        bit rdy;
        acc = 0; nrsp = 0; last = -1; cyc = 0;
        @(negedge clk);
        set_b2b(k, 0);
        req_valid[k] = 1'b1;
        while (acc < 6 && cyc < 200) begin
            rdy = req_ready[k];
            if (rsp_valid[k]) begin
                nrsp++;
                if (q_rd.size() == 0) check("b2b_extra_rsp", 32'd1, 32'd0);
                else begin
                    check("b2b_rdata", rsp_rdata[k], q_rd.pop_front());
                    check("b2b_err", 32'(rsp_err[k]), 32'(q_er.pop_front()));
                end
            end
            @(posedge clk);
            if (rdy) begin
                model_access(k, req_write[k], req_ltype[k], req_stype[k], req_addr[k],
                             req_wdata[k], e_rd, e_er);
                q_rd.push_back(e_rd);
                q_er.push_back(e_er);
                if (last >= 0) check("b2b_gap", 32'(cyc - last), 32'(ws(k) + 2));
                last = cyc;
                acc++;
                #1;
                if (acc < 6) set_b2b(k, acc);
                else req_valid[k] = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        check("b2b_accepts", 32'(acc), 32'd6);
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid[k]) begin
                nrsp++;
                if (q_rd.size() == 0) check("b2b_extra_rsp", 32'd1, 32'd0);
                else begin
                    check("b2b_rdata", rsp_rdata[k], q_rd.pop_front());
                    check("b2b_err", 32'(rsp_err[k]), 32'(q_er.pop_front()));
                end
            end
            @(negedge clk);
        end
        check("b2b_rsp_count", 32'(nrsp), 32'(acc));
    endtask

    typedef struct {
        string     name;
        bit        wr;
        bit [2:0]  lt;
        bit [1:0]  st;
        bit [31:0] addr;
        bit [31:0] wd;
        bit [31:0] rd;
        bit        er;
    } vec_t;

    initial begin
        vec_t        v[21];
        logic [31:0] rd;
        logic        er;
        bit   [31:0] e_rd;
        bit          e_er;
        bit          wr;
        bit   [2:0]  lt;
        bit   [1:0]  st;
        bit   [31:0] a, wd;

        v[0]  = '{"sw_10",      1, 3'd0, 2'd2, 32'h10,   32'hDEADBEEF, 32'h0,        0};
        v[1]  = '{"lw_10",      0, 3'd2, 2'd0, 32'h10,   32'h0,        32'hDEADBEEF, 0};
        v[2]  = '{"sw_10_zero", 1, 3'd0, 2'd2, 32'h10,   32'h0,        32'h0,        0};
        v[3]  = '{"sb_11",      1, 3'd0, 2'd0, 32'h11,   32'h12345680, 32'h0,        0};
        v[4]  = '{"lb_11",      0, 3'd0, 2'd0, 32'h11,   32'h0,        32'hFFFFFF80, 0};
        v[5]  = '{"lbu_11",     0, 3'd4, 2'd0, 32'h11,   32'h0,        32'h00000080, 0};
        v[6]  = '{"lw_10_sb",   0, 3'd2, 2'd0, 32'h10,   32'h0,        32'h00008000, 0};
        v[7]  = '{"lh_10",      0, 3'd1, 2'd0, 32'h10,   32'h0,        32'hFFFF8000, 0};
        v[8]  = '{"sw_20_zero", 1, 3'd0, 2'd2, 32'h20,   32'h0,        32'h0,        0};
        v[9]  = '{"sh_22",      1, 3'd0, 2'd1, 32'h22,   32'hABCD1234, 32'h0,        0};
        v[10] = '{"lw_20",      0, 3'd2, 2'd0, 32'h20,   32'h0,        32'h12340000, 0};
        v[11] = '{"lhu_22",     0, 3'd5, 2'd0, 32'h22,   32'h0,        32'h00001234, 0};
        v[12] = '{"lh_21_mis",  0, 3'd1, 2'd0, 32'h21,   32'h0,        32'h0,        1};
        v[13] = '{"sw_24",      1, 3'd0, 2'd2, 32'h24,   32'h11223344, 32'h0,        0};
        v[14] = '{"sw_26_mis",  1, 3'd0, 2'd2, 32'h26,   32'hAAAAAAAA, 32'h0,        1};
        v[15] = '{"lw_24",      0, 3'd2, 2'd0, 32'h24,   32'h0,        32'h11223344, 0};
        v[16] = '{"lw_range",   0, 3'd2, 2'd0, 32'h1000, 32'h0,        32'h0,        1};
        v[17] = '{"st_type11",  1, 3'd0, 2'd3, 32'h10,   32'hFFFFFFFF, 32'h0,        1};
        v[18] = '{"ld_type011", 0, 3'd3, 2'd0, 32'h10,   32'h0,        32'h0,        1};
        v[19] = '{"lw_12_mis",  0, 3'd2, 2'd0, 32'h12,   32'h0,        32'h0,        1};
        v[20] = '{"sw_30",      1, 3'd0, 2'd2, 32'h30,   32'h0BADF00D, 32'h0,        0};

        for (int k = 0; k < NI; k++) begin
            req_valid[k] = 1'b0;
            req_write[k] = 1'b0;
            req_ltype[k] = '0;
            req_stype[k] = '0;
            req_addr[k]  = '0;
            req_wdata[k] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            check("rst_ready", 32'(req_ready[k]), 32'd1);
            check("rst_valid", 32'(rsp_valid[k]), 32'd0);
            check("rst_rdata", rsp_rdata[k], 32'd0);
            check("rst_err", 32'(rsp_err[k]), 32'd0);
        end
        rst_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            do_txn(0, v[i].wr, v[i].lt, v[i].st, v[i].addr, v[i].wd, rd, er);
            check({v[i].name, "_rdata"}, rd, v[i].rd);
            check({v[i].name, "_err"}, 32'(er), 32'(v[i].er));
        end

        // Reset while a store sits in its wait state: it must never reach the RAM.
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_write[0] = 1'b1;
        req_stype[0] = 2'd2;
        req_addr[0]  = 32'h30;
        req_wdata[0] = 32'hA5A5A5A5;
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        @(negedge clk);
        check("wait_ready_low", 32'(req_ready[0]), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        check("rstw_valid", 32'(rsp_valid[0]), 32'd0);
        check("rstw_rdata", rsp_rdata[0], 32'd0);
        check("rstw_err", 32'(rsp_err[0]), 32'd0);
        check("rstw_ready", 32'(req_ready[0]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        do_txn(0, 1'b0, 3'd2, 2'd0, 32'h30, 32'h0, rd, er);
        check("lw_30_after_rst", rd, 32'h0BADF00D);
        check("lw_30_after_rst_err", 32'(er), 32'd0);

        // Reset while a response is on the outputs clears them asynchronously.
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_write[0] = 1'b0;
        req_ltype[0] = 3'd2;
        req_addr[0]  = 32'h24;
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rsp_before_rst", rsp_rdata[0], 32'h11223344);
        #1 rst_n = 1'b0;
        #1;
        check("rstr_valid", 32'(rsp_valid[0]), 32'd0);
        check("rstr_rdata", rsp_rdata[0], 32'd0);
        check("rstr_ready", 32'(req_ready[0]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < NI; k++) begin
            for (int w = 0; w < 16; w++) begin
                wd = $urandom;
                model_access(k, 1'b1, 3'd0, 2'd2, 32'(4 * w), wd, e_rd, e_er);
                do_txn(k, 1'b1, 3'd0, 2'd2, 32'(4 * w), wd, rd, er);
                check("init_err", 32'(er), 32'd0);
            end
            for (int i = 0; i < 60; i++) begin
                wr = 1'($urandom_range(0, 1));
                lt = 3'($urandom);
                st = 2'($urandom);
                a  = ($urandom_range(0, 9) == 0) ? 32'h1000 + $urandom_range(0, 255)
                                                 : 32'($urandom_range(0, 63));
                wd = $urandom;
                model_access(k, wr, lt, st, a, wd, e_rd, e_er);
                do_txn(k, wr, lt, st, a, wd, rd, er);
                check("rand_rdata", rd, e_rd);
                check("rand_err", 32'(er), 32'(e_er));
            end
        end

        b2b(1);
        b2b(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
